// File: rtl/tag_pool_if.sv
// Bus bundle for the free-tag pool: dispatch allocation port, retire free port,
// branch checkpoint controls and pool status.
interface tag_pool_if #(
  parameter int TAG_W = 5
);
  localparam int PTR_W = TAG_W + 1;

  // Handshake: dispatch raises alloc_en0 (and alloc_en1 for a second tag) and
  // reads alloc_tag0/1 in the same cycle; the tags are consumed on the rising
  // edge when alloc_stall is low, otherwise nothing is consumed. Frees have no
  // back-pressure: a free_valid tag is taken on the edge (or dropped with
  // overflow_err set if it would overfill the pool).
  logic             alloc_en0;
  logic             alloc_en1;
  logic [TAG_W-1:0] alloc_tag0;
  logic [TAG_W-1:0] alloc_tag1;
  logic             alloc_stall;
  logic             free_valid0;
  logic             free_valid1;
  logic [TAG_W-1:0] free_tag0;
  logic [TAG_W-1:0] free_tag1;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic             ckpt_valid;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow_err;

  modport master (
    output alloc_en0, alloc_en1, free_valid0, free_valid1, free_tag0, free_tag1,
           ckpt_save, ckpt_restore,
    input  alloc_tag0, alloc_tag1, alloc_stall, ckpt_valid, count, full, empty,
           overflow_err
  );

  modport slave (
    input  alloc_en0, alloc_en1, free_valid0, free_valid1, free_tag0, free_tag1,
           ckpt_save, ckpt_restore,
    output alloc_tag0, alloc_tag1, alloc_stall, ckpt_valid, count, full, empty,
           overflow_err
  );
endinterface

// File: rtl/tag_pool.sv
// Free-tag pool: circular tag store with 2-wide allocate, 2-wide free and a
// single read-pointer checkpoint for branch flush.
module tag_pool #(
  parameter int TAG_W = 5
) (
  input logic       clock,
  input logic       reset,
  tag_pool_if.slave bus
);
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int PTR_W    = TAG_W + 1;
  localparam logic [PTR_W-1:0] NUM_TAGS_P = PTR_W'(NUM_TAGS);
  localparam logic [PTR_W:0]   NUM_TAGS_X = (PTR_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0] mem [NUM_TAGS];
  logic [PTR_W-1:0] rptr, wptr, ckpt_ptr;
  logic             ckpt_valid_q;
  logic             overflow_q;

  logic [PTR_W-1:0] count_w, rptr_grant, wptr_next, restore_span;
  logic [TAG_W-1:0] ridx0, ridx1, widx0, widx1;
  logic [1:0]       req, grant, nfree, nfree_ok;
  logic [PTR_W:0]   occ_next;
  logic             free_drop, restore_ok, restore_bad;

  assign count_w = wptr - rptr;
  assign ridx0   = rptr[TAG_W-1:0];
  assign ridx1   = ridx0 + TAG_W'(1);
  assign widx0   = wptr[TAG_W-1:0];
  assign widx1   = widx0 + TAG_W'(1);

  assign req   = bus.alloc_en0 ? (bus.alloc_en1 ? 2'd2 : 2'd1) : 2'd0;
  // Grant is all-or-nothing against the registered count; frees landing this
  // cycle are not visible until the next one.
  assign grant = (({{(PTR_W-2){1'b0}}, req} <= count_w) && !bus.ckpt_restore)
                 ? req : 2'd0;
  assign nfree = {1'b0, bus.free_valid0} + {1'b0, bus.free_valid1};

  assign occ_next   = {1'b0, count_w} - (PTR_W+1)'(grant) + (PTR_W+1)'(nfree);
  assign free_drop  = occ_next > NUM_TAGS_X;
  assign nfree_ok   = free_drop ? 2'd0 : nfree;
  assign wptr_next  = wptr + PTR_W'(nfree_ok);
  assign rptr_grant = rptr + PTR_W'(grant);

  // A rollback that would leave more than NUM_TAGS tags outstanding in the pool
  // means the checkpoint is stale; refuse it rather than corrupt the ring.
  assign restore_span = wptr_next - ckpt_ptr;
  assign restore_ok   = bus.ckpt_restore && ckpt_valid_q && (restore_span <= NUM_TAGS_P);
  assign restore_bad  = bus.ckpt_restore && !restore_ok;

  assign bus.alloc_tag0   = mem[ridx0];
  assign bus.alloc_tag1   = mem[ridx1];
  assign bus.alloc_stall  = (req != 2'd0) && (grant == 2'd0);
  assign bus.count        = count_w;
  assign bus.full         = (count_w == NUM_TAGS_P);
  assign bus.empty        = (count_w == '0);
  assign bus.ckpt_valid   = ckpt_valid_q;
  assign bus.overflow_err = overflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        mem[i] <= TAG_W'(i);
      end
      rptr         <= '0;
      wptr         <= NUM_TAGS_P;
      ckpt_ptr     <= '0;
      ckpt_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (!free_drop) begin
        if (bus.free_valid0) mem[widx0] <= bus.free_tag0;
        if (bus.free_valid1) mem[bus.free_valid0 ? widx1 : widx0] <= bus.free_tag1;
      end
      wptr <= wptr_next;

      // Save alongside a valid restore keeps the restored pointer as the snapshot.
      if (restore_ok) begin
        rptr         <= ckpt_ptr;
        ckpt_valid_q <= bus.ckpt_save;
      end else begin
        rptr <= rptr_grant;
        if (bus.ckpt_save) begin
          ckpt_ptr     <= rptr_grant;
          ckpt_valid_q <= 1'b1;
        end
      end

      if (free_drop || restore_bad) overflow_q <= 1'b1;
    end
  end
endmodule

// File: doc/tag_pool.md
# tag_pool

Parametrised free-tag pool for the dispatch/retire loop. Supersedes the single-port tag FIFO. Holds up to NUM_TAGS free tags, preloaded with 0..NUM_TAGS-1. Each cycle it can hand out 0–2 tags to dispatch and accept 0–2 tags back from the retire bus. A single checkpoint lets a branch flush return all tags allocated after the checkpoint in one cycle.

## Interface
- TAG_W, 5, tag width; NUM_TAGS = 1<<TAG_W (derived, not overridable)
- PTR_W, TAG_W+1, pointer/count width (derived)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alloc_en0  in  1  dispatch requests one tag
- alloc_en1  in  1  dispatch requests a second tag; ignored unless alloc_en0=1
- alloc_tag0  out  TAG_W  head tag, mem[rptr] (show-ahead)
- alloc_tag1  out  TAG_W  next tag, mem[rptr+1]
- alloc_stall  out  1  request not granted this cycle
- free_valid0, free_valid1  in  1 each  retire bus returns a tag
- free_tag0, free_tag1  in  TAG_W each  returned tags
- ckpt_save  in  1  snapshot the read pointer
- ckpt_restore  in  1  roll the read pointer back to the snapshot
- ckpt_valid  out  1  snapshot held
- count  out  PTR_W  free tags held = wptr - rptr
- full  out  1  count == NUM_TAGS
- empty  out  1  count == 0
- overflow_err  out  1  sticky protocol-error flag

## Operation
- Storage: NUM_TAGS x TAG_W array. Pointers rptr and wptr are PTR_W bits wide and wrap modulo 2^PTR_W. Array index = pointer[TAG_W-1:0].
- Reset: mem[i]=i; rptr=0; wptr=NUM_TAGS; ckpt_ptr=0; ckpt_valid=0; overflow_err=0.
  - Resulting outputs: count=NUM_TAGS, full=1, empty=0, alloc_tag0=0, alloc_tag1=1, alloc_stall=0.
- Request count: req = alloc_en0 ? (1 + alloc_en1) : 0.
- Grant rule:
  - All-or-nothing: grant = req, if req <= count and ckpt_restore=0; otherwise grant = 0.
  - alloc_stall = (req != 0) && (grant == 0).
  - count is the registered value; same-cycle frees are never bypassed.
- On grant: rptr += grant. Dispatch consumes alloc_tag0 (and alloc_tag1 when granted 2) in that cycle.
- Free ordering:
  - Both free_valid0 and free_valid1: write free_tag0 at wptr, free_tag1 at wptr+1.
  - Only one valid: write that tag at wptr.
  - Then wptr += nfree.
- Overflow guard: if count - grant + nfree > NUM_TAGS, drop all frees this cycle and set overflow_err. Allocation still proceeds.
- ckpt_save: ckpt_ptr <= rptr after this cycle's grant; ckpt_valid <= 1. A later save overwrites an earlier one.
- ckpt_restore:
  - Requires ckpt_valid=1; if ckpt_valid=0, the restore is ignored and overflow_err is set.
  - Valid restore: rptr <= ckpt_ptr; ckpt_valid <= 0; allocation is blocked that cycle.
  - Frees are still processed normally on a restore cycle.
  - If wptr_next - ckpt_ptr > NUM_TAGS, the restore is ignored and overflow_err is set.
- Save and restore in the same cycle: restore wins. ckpt_ptr <= restored value, ckpt_valid stays 1.
- overflow_err clears only on reset.

## Timing
- alloc_tag0/1, count, full, empty and ckpt_valid are combinational from registers and stable for the whole cycle.
- alloc_stall is combinational from alloc_en*, ckpt_restore and count (same-cycle handshake).
- All state updates on the rising clock edge. A freed tag can be allocated 1 cycle after its free cycle at the earliest.
- Wrap: pointers roll over past 2^PTR_W-1 with no glitch in count/full/empty.
- Asynchronous reset mid-operation: all state returns to reset values immediately, regardless of clock. The first grant is possible in the first cycle after deassertion.

## Test plan
- **Reset/drain by 2:** after reset, alloc_en0=alloc_en1=1 for 16 cycles.
  - Required: tags 0,1 / 2,3 / … / 30,31 granted in order; then empty=1, count=0.
  - 17th request: alloc_stall=1, pointers unchanged.
- **Partial grant refused:** count=1, request 2.
  - Required: alloc_stall=1, count stays 1.
  - Request 1 next cycle: tag granted, empty=1.
- **Free order and wrap:** drain all tags, then free (7,3) in one cycle, then free1-only tag 9.
  - Required: next allocations yield 7,3,9.
  - Repeat 100 full alloc/free cycles: count never exceeds 32, wptr wraps cleanly.
- **Checkpoint rollback:** after reset, alloc 4 (tags 0–3), ckpt_save, alloc 6 (tags 4–9), ckpt_restore.
  - Required: count=28 and alloc_tag0=4.
  - A concurrent free of tag 0 on the restore cycle gives count=29 next cycle.
- **Overflow/illegal restore:** free a tag while full=1.
  - Required: tag dropped, count=32, overflow_err=1 sticky.
  - ckpt_restore with ckpt_valid=0: ignored, pointers unchanged.
- **Reset mid-burst:** assert reset between edges during alloc/free traffic.
  - Required: outputs immediately return to count=32, full=1, alloc_tag0=0, alloc_tag1=1, overflow_err=0.
